mem_quad_sched: RTL and testbench
=================================

Name: mem_quad_sched

Overview:
- Per-pair request scheduler in front of the pseudo quad-port memory (two dual-port banks split on address LSB).
- Each of two lanes accepts one write stream and one read stream. The lane issues the read and write in the same cycle only when their address LSBs differ.
- On an LSB conflict the write is deferred in a one-entry per-lane buffer. Reads bypass it with data forwarding, and an age limit prevents write starvation.

Parameters:
- WIDTH, 8, data word width.
- DEPTH, 64, memory depth in words. ADDR_W = `CLOG2(DEPTH).
- MAX_DEFER, 4, maximum consecutive cycles a buffered write may be deferred before it is forced.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- drain  in  1  write-priority mode: conflicting reads stall until the buffers are empty
- idle  out  1  both lane buffers empty
- wr_valid0/wr_valid1  in  1  write request per lane
- wr_ready0/wr_ready1  out  1  write accepted this cycle
- wr_addr0/wr_addr1  in  ADDR_W  write address
- wr_data0/wr_data1  in  WIDTH  write data
- rd_valid0/rd_valid1  in  1  read request
- rd_ready0/rd_ready1  out  1  read accepted this cycle
- rd_addr0/rd_addr1  in  ADDR_W  read address
- rd_data0/rd_data1  out  WIDTH  read result
- rd_dvalid0/rd_dvalid1  out  1  rd_data valid
- mem_data0/mem_data1  out  WIDTH  memory write data
- mem_wraddress0/mem_wraddress1  out  ADDR_W  memory write address
- mem_wren0/mem_wren1  out  1  memory write enable
- mem_rdaddress0/mem_rdaddress1  out  ADDR_W  memory read address
- mem_rden0/mem_rden1  out  1  memory read enable
- mem_q0/mem_q1  in  WIDTH  memory read data, valid 1 cycle after mem_rden

Behaviour:
- Reset (rst_n=0 at a clk edge): buffers EMPTY, age=0, rd_dvalid=0, rd_data=0, idle=1.
  - mem_wren, mem_rden, mem_* addresses and mem_data are combinational, so they are 0 while rst_n=0.
  - A reset in mid-operation discards buffered writes and in-flight read returns.
- Lane state: EMPTY or HELD. HELD stores buf_addr, buf_data and age (width `CLOG2(MAX_DEFER+1)).
- Per lane, per cycle, candidate write W:
  - In HELD, W is the buffer entry.
  - Otherwise W is the incoming write when wr_valid.
- R is the incoming read.
- conflict = W present && R valid && W.addr[0]==R.addr[0].
- force = HELD && (age==MAX_DEFER || drain).
- rd_ready = !(conflict && force).
- Issue rules:
  - No conflict: issue W (if present) and R (if valid) together.
  - Conflict && !force: issue R. W is not issued; it enters or stays in the buffer and age increments (age resets to 0 on entry).
  - Conflict && force: issue W only; R is stalled (rd_ready=0).
  - drain with EMPTY and wr_valid: the incoming write is W. The conflict is resolved as !force, so the write is buffered.
- wr_ready:
  - EMPTY: wr_ready = 1. The incoming write is issued directly or captured into the buffer.
  - HELD: wr_ready = 1 only if the buffer entry issues this cycle; the incoming write is then captured into the buffer with age 0.
- Buffer exit: HELD returns to EMPTY when its entry issues and no new write is captured.
- Memory outputs:
  - mem_wren=1 with W address/data on write issue.
  - mem_rden=1 with R address on read issue.
- Read return: rd_dvalid asserts exactly 1 cycle after read issue.
  - rd_data = registered fwd_data when fwd_hit, otherwise mem_q.
  - fwd_hit = lane was HELD at the start of the issue cycle && buf_addr==rd_addr. The entry stays buffered that cycle, because equal addresses always conflict.
- Ordering:
  - A same-cycle incoming write to the read address never forwards; the read returns the prior value.
  - Forwarding is per lane only. Cross-lane read-after-write coherence and simultaneous writes to the same address from both lanes are the caller's responsibility.
- idle = both lanes EMPTY. It is combinational from state.

Decomposition:
- Shared package/header holds:
  - the ADDR_W derivation via `CLOG2;
  - a localparam for the lane state encoding (EMPTY=0, HELD=1).
- One natural sub-module, mem_quad_sched_lane, holds:
  - the buffer, age counter, issue logic and forwarding registers.
- It is instantiated twice. The top only wires the lanes and ANDs idle.

Test Plan:
- Lane0 write 0x10 data 0xA5 with read 0x03, same cycle: both issue; mem_wren0=1 addr 0x10, mem_rden0=1 addr 0x03; rd_dvalid0 next cycle with mem_q0.
- Lane0 write 0x04 data 0x3C with read 0x06:
  - read issues; write buffered; wr_ready0=1, idle=0.
  - Next cycle with no read: buffer drains, mem_wren0 addr 0x04, idle=1.
- Buffered write 0x08 data 0x77, then read 0x08: rd_dvalid0 next cycle, rd_data0=0x77 regardless of mem_q0.
- Buffered write at even address with even-address reads every cycle and MAX_DEFER=4: after 4 deferrals, rd_ready0=0 for one cycle, the write issues, and the read issues the following cycle.
- drain=1 with lane1 HELD and a conflicting read: rd_ready1=0, the write issues, idle rises; lane0 is unaffected.
- Assert rst_n=0 while lane0 is HELD and a read is in flight: the next cycle has idle=1 and rd_dvalid0=0, and the deferred write never appears on mem_wren0.

Source files
------------

// File: rtl/mem_quad_sched_pkg.sv
// Shared definitions for the pseudo quad-port memory scheduler:
// address width derivation, lane state encoding and default sizes.

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package mem_quad_sched_pkg;

  // Lane buffer state encoding: a lane either has no deferred write or holds one
  localparam logic LANE_EMPTY_ENC = 1'b0;
  localparam logic LANE_HELD_ENC  = 1'b1;

  typedef enum logic {
    LANE_EMPTY = LANE_EMPTY_ENC,
    LANE_HELD  = LANE_HELD_ENC
  } lane_state_t;

  // Default geometry of the scheduler
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 64;
  localparam int DEF_MAX_DEFER = 4;
  localparam int DEF_ADDR_W    = `CLOG2(DEF_DEPTH);

  // Width of the age counter, which must be able to hold MAX_DEFER itself
  function automatic int age_width(input int max_defer);
    return (`CLOG2(max_defer + 1) < 1) ? 1 : `CLOG2(max_defer + 1);
  endfunction

endpackage

// File: rtl/mem_quad_sched_lane.sv
// One scheduler lane: a write stream and a read stream sharing a bank pair.
// A write whose address LSB collides with the read is parked in a one-entry
// buffer; reads to the parked address are served from the buffer, and an age
// counter forces the parked write out after MAX_DEFER deferrals.

module mem_quad_sched_lane
  import mem_quad_sched_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_DEFER = DEF_MAX_DEFER
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drain,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_dvalid,
  input  logic [WIDTH-1:0]  mem_q,
  output logic [WIDTH-1:0]  mem_data,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_rdaddress,
  output logic              mem_rden,
  output logic              empty
);

  localparam int AGE_W = age_width(MAX_DEFER);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_DEFER);

  lane_state_t       state, state_next;
  logic [ADDR_W-1:0] buf_addr, buf_addr_next;
  logic [WIDTH-1:0]  buf_data, buf_data_next;
  logic [AGE_W-1:0]  age, age_next;

  logic              held;
  logic              w_present;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_data;
  logic              conflict;
  logic              force_w;
  logic              issue_w;
  logic              issue_r;
  logic              accept_w;
  logic              capture;
  logic              fwd_hit;

  logic              dvalid_q;
  logic              fwd_hit_q;
  logic [WIDTH-1:0]  fwd_data_q;

  // Buffer state register: parked write, its age and the lane state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= LANE_EMPTY;
      buf_addr <= '0;
      buf_data <= '0;
      age      <= '0;
    end else begin
      state    <= state_next;
      buf_addr <= buf_addr_next;
      buf_data <= buf_data_next;
      age      <= age_next;
    end
  end

  // Pick the candidate write, resolve the bank conflict and decide what issues
  always_comb begin
    state_next    = state;
    buf_addr_next = buf_addr;
    buf_data_next = buf_data;
    age_next      = age;

    held      = (state == LANE_HELD);
    w_present = held || wr_valid;
    w_addr    = held ? buf_addr : wr_addr;
    w_data    = held ? buf_data : wr_data;
    conflict  = w_present && rd_valid && (w_addr[0] == rd_addr[0]);
    force_w   = held && ((age == AGE_MAX) || drain);
    issue_w   = w_present && (!conflict || force_w);
    issue_r   = rd_valid && !(conflict && force_w);
    accept_w  = !held || issue_w;
    capture   = wr_valid && accept_w && (held || !issue_w);
    fwd_hit   = held && (buf_addr == rd_addr);

    if (capture) begin
      state_next    = LANE_HELD;
      buf_addr_next = wr_addr;
      buf_data_next = wr_data;
      age_next      = '0;
    end else if (held && issue_w) begin
      state_next = LANE_EMPTY;
      age_next   = '0;
    end else if (held) begin
      age_next = age + AGE_W'(1);
    end

    wr_ready      = rst_n && accept_w;
    rd_ready      = rst_n && !(conflict && force_w);
    mem_wren      = rst_n && issue_w;
    mem_wraddress = (rst_n && issue_w) ? w_addr : '0;
    mem_data      = (rst_n && issue_w) ? w_data : '0;
    mem_rden      = rst_n && issue_r;
    mem_rdaddress = (rst_n && issue_r) ? rd_addr : '0;
    empty         = !held;
  end

  // Read return pipeline: remember whether the issued read hit the parked write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvalid_q   <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      dvalid_q   <= issue_r;
      fwd_hit_q  <= issue_r && fwd_hit;
      fwd_data_q <= buf_data;
    end
  end

  // Return data comes from the forwarding register on a hit, else from memory
  always_comb begin
    rd_dvalid = dvalid_q;
    rd_data   = '0;
    if (dvalid_q) begin
      rd_data = fwd_hit_q ? fwd_data_q : mem_q;
    end
  end

endmodule

// File: rtl/mem_quad_sched.sv
// Two-lane request scheduler in front of the pseudo quad-port memory.
// Each lane is independent; the top only wires them and reports idle.

module mem_quad_sched
  import mem_quad_sched_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MAX_DEFER = DEF_MAX_DEFER,
  localparam int ADDR_W   = `CLOG2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drain,
  output logic              idle,
  input  logic              wr_valid0,
  input  logic              wr_valid1,
  output logic              wr_ready0,
  output logic              wr_ready1,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [WIDTH-1:0]  wr_data0,
  input  logic [WIDTH-1:0]  wr_data1,
  input  logic              rd_valid0,
  input  logic              rd_valid1,
  output logic              rd_ready0,
  output logic              rd_ready1,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [WIDTH-1:0]  rd_data0,
  output logic [WIDTH-1:0]  rd_data1,
  output logic              rd_dvalid0,
  output logic              rd_dvalid1,
  output logic [WIDTH-1:0]  mem_data0,
  output logic [WIDTH-1:0]  mem_data1,
  output logic [ADDR_W-1:0] mem_wraddress0,
  output logic [ADDR_W-1:0] mem_wraddress1,
  output logic              mem_wren0,
  output logic              mem_wren1,
  output logic [ADDR_W-1:0] mem_rdaddress0,
  output logic [ADDR_W-1:0] mem_rdaddress1,
  output logic              mem_rden0,
  output logic              mem_rden1,
  input  logic [WIDTH-1:0]  mem_q0,
  input  logic [WIDTH-1:0]  mem_q1
);

  logic empty0;
  logic empty1;

  mem_quad_sched_lane #(
    .WIDTH    (WIDTH),
    .ADDR_W   (ADDR_W),
    .MAX_DEFER(MAX_DEFER)
  ) u_lane0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .drain        (drain),
    .wr_valid     (wr_valid0),
    .wr_addr      (wr_addr0),
    .wr_data      (wr_data0),
    .wr_ready     (wr_ready0),
    .rd_valid     (rd_valid0),
    .rd_addr      (rd_addr0),
    .rd_ready     (rd_ready0),
    .rd_data      (rd_data0),
    .rd_dvalid    (rd_dvalid0),
    .mem_q        (mem_q0),
    .mem_data     (mem_data0),
    .mem_wraddress(mem_wraddress0),
    .mem_wren     (mem_wren0),
    .mem_rdaddress(mem_rdaddress0),
    .mem_rden     (mem_rden0),
    .empty        (empty0)
  );

  mem_quad_sched_lane #(
    .WIDTH    (WIDTH),
    .ADDR_W   (ADDR_W),
    .MAX_DEFER(MAX_DEFER)
  ) u_lane1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .drain        (drain),
    .wr_valid     (wr_valid1),
    .wr_addr      (wr_addr1),
    .wr_data      (wr_data1),
    .wr_ready     (wr_ready1),
    .rd_valid     (rd_valid1),
    .rd_addr      (rd_addr1),
    .rd_ready     (rd_ready1),
    .rd_data      (rd_data1),
    .rd_dvalid    (rd_dvalid1),
    .mem_q        (mem_q1),
    .mem_data     (mem_data1),
    .mem_wraddress(mem_wraddress1),
    .mem_wren     (mem_wren1),
    .mem_rdaddress(mem_rdaddress1),
    .mem_rden     (mem_rden1),
    .empty        (empty1)
  );

  // The scheduler is idle once neither lane holds a deferred write
  always_comb begin
    idle = empty0 && empty1;
  end

endmodule

// File: tb/tb_mem_quad_sched.sv
// Directed self-checking bench for mem_quad_sched: each step drives inputs
// on the falling edge and checks outputs 1 time unit later.

module tb_mem_quad_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       drain;
  logic       idle;
  logic       wr_valid0, wr_valid1;
  logic       wr_ready0, wr_ready1;
  logic [5:0] wr_addr0, wr_addr1;
  logic [7:0] wr_data0, wr_data1;
  logic       rd_valid0, rd_valid1;
  logic       rd_ready0, rd_ready1;
  logic [5:0] rd_addr0, rd_addr1;
  logic [7:0] rd_data0, rd_data1;
  logic       rd_dvalid0, rd_dvalid1;
  logic [7:0] mem_data0, mem_data1;
  logic [5:0] mem_wraddress0, mem_wraddress1;
  logic       mem_wren0, mem_wren1;
  logic [5:0] mem_rdaddress0, mem_rdaddress1;
  logic       mem_rden0, mem_rden1;
  logic [7:0] mem_q0, mem_q1;

  int checks = 0;
  int errors = 0;

  mem_quad_sched #(.WIDTH(8), .DEPTH(64), .MAX_DEFER(4)) dut (
    .clk(clk), .rst_n(rst_n), .drain(drain), .idle(idle),
    .wr_valid0(wr_valid0), .wr_valid1(wr_valid1),
    .wr_ready0(wr_ready0), .wr_ready1(wr_ready1),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
    .rd_ready0(rd_ready0), .rd_ready1(rd_ready1),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .rd_dvalid0(rd_dvalid0), .rd_dvalid1(rd_dvalid1),
    .mem_data0(mem_data0), .mem_data1(mem_data1),
    .mem_wraddress0(mem_wraddress0), .mem_wraddress1(mem_wraddress1),
    .mem_wren0(mem_wren0), .mem_wren1(mem_wren1),
    .mem_rdaddress0(mem_rdaddress0), .mem_rdaddress1(mem_rdaddress1),
    .mem_rden0(mem_rden0), .mem_rden1(mem_rden1),
    .mem_q0(mem_q0), .mem_q1(mem_q1)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge and clear every request input
  task automatic applyStimulus();
    @(negedge clk);
    drain     = 1'b0;
    wr_valid0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
    wr_valid1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
    rd_valid0 = 1'b0; rd_addr0 = '0;
    rd_valid1 = 1'b0; rd_addr1 = '0;
  endtask

  initial begin
    rst_n  = 1'b0;
    mem_q0 = 8'h11;
    mem_q1 = 8'h22;
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("reset_idle", 32'(idle), 32'd1);
    checkOutput("reset_dvalid0", 32'(rd_dvalid0), 32'd0);
    checkOutput("reset_rd_data0", 32'(rd_data0), 32'd0);
    checkOutput("reset_wren0", 32'(mem_wren0), 32'd0);
    checkOutput("reset_rden0", 32'(mem_rden0), 32'd0);

    // Non-conflicting write and read issue together
    applyStimulus();
    rst_n = 1'b1;
    wr_valid0 = 1'b1; wr_addr0 = 6'h10; wr_data0 = 8'hA5;
    rd_valid0 = 1'b1; rd_addr0 = 6'h03;
    #1;
    checkOutput("t1_wren", 32'(mem_wren0), 32'd1);
    checkOutput("t1_wraddr", 32'(mem_wraddress0), 32'h10);
    checkOutput("t1_wdata", 32'(mem_data0), 32'hA5);
    checkOutput("t1_rden", 32'(mem_rden0), 32'd1);
    checkOutput("t1_rdaddr", 32'(mem_rdaddress0), 32'h03);
    checkOutput("t1_wr_ready", 32'(wr_ready0), 32'd1);
    checkOutput("t1_rd_ready", 32'(rd_ready0), 32'd1);
    applyStimulus();
    mem_q0 = 8'h5A;
    #1;
    checkOutput("t1_dvalid", 32'(rd_dvalid0), 32'd1);
    checkOutput("t1_rd_data", 32'(rd_data0), 32'h5A);
    checkOutput("t1_wren_off", 32'(mem_wren0), 32'd0);

    // Same-LSB conflict: read issues, write is parked then drains
    applyStimulus();
    wr_valid0 = 1'b1; wr_addr0 = 6'h04; wr_data0 = 8'h3C;
    rd_valid0 = 1'b1; rd_addr0 = 6'h06;
    #1;
    checkOutput("t2_rden", 32'(mem_rden0), 32'd1);
    checkOutput("t2_rdaddr", 32'(mem_rdaddress0), 32'h06);
    checkOutput("t2_wren", 32'(mem_wren0), 32'd0);
    checkOutput("t2_wr_ready", 32'(wr_ready0), 32'd1);
    applyStimulus();
    mem_q0 = 8'hC3;
    #1;
    checkOutput("t2_idle_busy", 32'(idle), 32'd0);
    checkOutput("t2_drain_wren", 32'(mem_wren0), 32'd1);
    checkOutput("t2_drain_addr", 32'(mem_wraddress0), 32'h04);
    checkOutput("t2_drain_data", 32'(mem_data0), 32'h3C);
    checkOutput("t2_rd_data", 32'(rd_data0), 32'hC3);
    applyStimulus();
    #1;
    checkOutput("t2_idle_back", 32'(idle), 32'd1);
    checkOutput("t2_wren_off", 32'(mem_wren0), 32'd0);

    // Read of a parked address is forwarded from the buffer
    applyStimulus();
    wr_valid0 = 1'b1; wr_addr0 = 6'h08; wr_data0 = 8'h77;
    rd_valid0 = 1'b1; rd_addr0 = 6'h0A;
    #1;
    checkOutput("t3_park_wren", 32'(mem_wren0), 32'd0);
    applyStimulus();
    rd_valid0 = 1'b1; rd_addr0 = 6'h08;
    #1;
    checkOutput("t3_hit_rd_ready", 32'(rd_ready0), 32'd1);
    checkOutput("t3_hit_rden", 32'(mem_rden0), 32'd1);
    checkOutput("t3_hit_wren", 32'(mem_wren0), 32'd0);
    applyStimulus();
    mem_q0 = 8'hEE;
    #1;
    checkOutput("t3_fwd_dvalid", 32'(rd_dvalid0), 32'd1);
    checkOutput("t3_fwd_data", 32'(rd_data0), 32'h77);
    checkOutput("t3_drain_wren", 32'(mem_wren0), 32'd1);
    checkOutput("t3_drain_addr", 32'(mem_wraddress0), 32'h08);
    applyStimulus();
    #1;
    checkOutput("t3_idle", 32'(idle), 32'd1);

    // Age limit: four deferrals, then the write is forced and the read stalls
    applyStimulus();
    wr_valid0 = 1'b1; wr_addr0 = 6'h20; wr_data0 = 8'h99;
    rd_valid0 = 1'b1; rd_addr0 = 6'h02;
    #1;
    checkOutput("t4_enter_wren", 32'(mem_wren0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      rd_valid0 = 1'b1; rd_addr0 = 6'h02;
      #1;
      checkOutput($sformatf("t4_defer%0d_rd_ready", i), 32'(rd_ready0), 32'd1);
      checkOutput($sformatf("t4_defer%0d_wren", i), 32'(mem_wren0), 32'd0);
    end
    applyStimulus();
    rd_valid0 = 1'b1; rd_addr0 = 6'h02;
    #1;
    checkOutput("t4_force_rd_ready", 32'(rd_ready0), 32'd0);
    checkOutput("t4_force_rden", 32'(mem_rden0), 32'd0);
    checkOutput("t4_force_wren", 32'(mem_wren0), 32'd1);
    checkOutput("t4_force_addr", 32'(mem_wraddress0), 32'h20);
    checkOutput("t4_force_data", 32'(mem_data0), 32'h99);
    applyStimulus();
    rd_valid0 = 1'b1; rd_addr0 = 6'h02;
    #1;
    checkOutput("t4_after_rd_ready", 32'(rd_ready0), 32'd1);
    checkOutput("t4_after_rden", 32'(mem_rden0), 32'd1);
    checkOutput("t4_after_wren", 32'(mem_wren0), 32'd0);
    checkOutput("t4_after_dvalid", 32'(rd_dvalid0), 32'd0);
    checkOutput("t4_after_idle", 32'(idle), 32'd1);

    // Drain mode on lane1 while lane0 keeps reading
    applyStimulus();
    wr_valid1 = 1'b1; wr_addr1 = 6'h12; wr_data1 = 8'h44;
    rd_valid1 = 1'b1; rd_addr1 = 6'h14;
    wr_valid0 = 1'b1; wr_addr0 = 6'h01; wr_data0 = 8'h55;
    rd_valid0 = 1'b1; rd_addr0 = 6'h02;
    #1;
    checkOutput("t5_l1_park_wren", 32'(mem_wren1), 32'd0);
    checkOutput("t5_l0_wren", 32'(mem_wren0), 32'd1);
    applyStimulus();
    drain = 1'b1;
    rd_valid1 = 1'b1; rd_addr1 = 6'h16;
    rd_valid0 = 1'b1; rd_addr0 = 6'h05;
    #1;
    checkOutput("t5_idle_busy", 32'(idle), 32'd0);
    checkOutput("t5_l1_rd_ready", 32'(rd_ready1), 32'd0);
    checkOutput("t5_l1_rden", 32'(mem_rden1), 32'd0);
    checkOutput("t5_l1_wren", 32'(mem_wren1), 32'd1);
    checkOutput("t5_l1_wraddr", 32'(mem_wraddress1), 32'h12);
    checkOutput("t5_l1_wdata", 32'(mem_data1), 32'h44);
    checkOutput("t5_l0_rd_ready", 32'(rd_ready0), 32'd1);
    checkOutput("t5_l0_rden", 32'(mem_rden0), 32'd1);
    applyStimulus();
    #1;
    checkOutput("t5_idle_back", 32'(idle), 32'd1);
    checkOutput("t5_l1_dvalid", 32'(rd_dvalid1), 32'd0);
    checkOutput("t5_l0_dvalid", 32'(rd_dvalid0), 32'd1);

    // Reset while a write is parked and a read is in flight
    applyStimulus();
    wr_valid0 = 1'b1; wr_addr0 = 6'h30; wr_data0 = 8'h66;
    rd_valid0 = 1'b1; rd_addr0 = 6'h32;
    #1;
    checkOutput("t6_park_wren", 32'(mem_wren0), 32'd0);
    applyStimulus();
    rd_valid0 = 1'b1; rd_addr0 = 6'h34;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_busy", 32'(idle), 32'd0);
    applyStimulus();
    rst_n = 1'b1;
    #1;
    checkOutput("t6_idle", 32'(idle), 32'd1);
    checkOutput("t6_dvalid", 32'(rd_dvalid0), 32'd0);
    checkOutput("t6_wren", 32'(mem_wren0), 32'd0);
    applyStimulus();
    #1;
    checkOutput("t6_wren_later", 32'(mem_wren0), 32'd0);
    checkOutput("t6_dvalid_later", 32'(rd_dvalid0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
